axis_flit_injector: RTL and testbench

- Injection-side stage feeding a router's local input port (port 0).
- Accepts AXI-stream beats in the NoC clock domain and splits each beat into SERIALIZATION_FACTOR flits.
- Drives the router's data/dest/is_tail/send flit interface under credit-based flow control.
- Tracks downstream input-buffer occupancy with a credit counter initialised to FLIT_BUFFER_DEPTH.

---
 rtl/axis_flit_injector.sv | 154 +++++++++++++++
 tb/tb_axis_flit_injector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_flit_injector.sv
// axis_flit_injector
//   Injection stage for a router's local input port. Each accepted AXI-stream
//   beat is held and emitted as SERIALIZATION_FACTOR flits, least-significant
//   slice first, under credit-based flow control against the router's input
//   buffer (FLIT_BUFFER_DEPTH credits at reset).
//
// Ports
//   clk_noc, rst_noc_sync            clock; synchronous active-high reset
//   axis_tvalid/tready/tdata/tlast   AXI-stream beat input
//   axis_tid/tdest                   stream id / destination, sent as {tid,tdest}
//   data_out/dest_out/is_tail_out    flit fields towards the router
//   send_out                         one pulse per flit
//   credit_in                        one credit returned per asserted cycle
//   credit_count                     current credit count
//   credit_overflow                  sticky: credit returned while already full
//
// Optional build macro AXIS_FLIT_INJECTOR_PERF_CNT_EN adds the 32-bit counters
//   perf_flits_sent and perf_credit_stalls.
module axis_flit_injector #(
   parameter int TDATA_WIDTH          = 32,
   parameter int TDEST_WIDTH          = 4,
   parameter int TID_WIDTH            = 2,
   parameter int SERIALIZATION_FACTOR = 2,
   parameter int FLIT_BUFFER_DEPTH    = 8,
   parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
   parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
   parameter int CW                   = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                   clk_noc,
   input  logic                   rst_noc_sync,
   input  logic                   axis_tvalid,
   output logic                   axis_tready,
   input  logic [TDATA_WIDTH-1:0] axis_tdata,
   input  logic                   axis_tlast,
   input  logic [TID_WIDTH-1:0]   axis_tid,
   input  logic [TDEST_WIDTH-1:0] axis_tdest,
   output logic [FLIT_WIDTH-1:0]  data_out,
   output logic [DEST_WIDTH-1:0]  dest_out,
   output logic                   is_tail_out,
   output logic                   send_out,
   input  logic                   credit_in,
   output logic [CW-1:0]          credit_count,
`ifdef AXIS_FLIT_INJECTOR_PERF_CNT_EN
   output logic [31:0]            perf_flits_sent,
   output logic [31:0]            perf_credit_stalls,
`endif
   output logic                   credit_overflow
);

   localparam int IW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FLIT_BUFFER_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(SERIALIZATION_FACTOR - 1);

   logic [0:0]             r_state;
   logic [IW-1:0]          r_flit_idx;
   logic [TDATA_WIDTH-1:0] r_data;
   logic [DEST_WIDTH-1:0]  r_dest;
   logic                   r_tlast;
   logic [CW-1:0]          r_credit;
   logic                   r_overflow;

   logic          w_send;
   logic          w_last_idx;
   logic          w_last_send;
   logic          w_ready;
   logic          w_accept;
   logic [CW-1:0] w_credit_next;
   logic          w_ovf_event;

   // With SERIALIZATION_FACTOR==1 LAST_IDX is 0, so the index never leaves 0.
   assign w_last_idx  = (r_flit_idx == LAST_IDX);
   // Gated by reset so nothing is sent or accepted in the reset cycle itself.
   assign w_send      = ~rst_noc_sync & (r_state == ST_SEND) & (r_credit != '0);
   assign w_last_send = w_send & w_last_idx;
   assign w_ready     = ~rst_noc_sync & ((r_state == ST_IDLE) | w_last_send);
   assign w_accept    = w_ready & axis_tvalid;

   assign axis_tready     = w_ready;
   assign send_out        = w_send;
   assign data_out        = r_data[r_flit_idx * FLIT_WIDTH +: FLIT_WIDTH];
   assign dest_out        = r_dest;
   assign is_tail_out     = r_tlast & w_last_idx;
   assign credit_count    = r_credit;
   assign credit_overflow = r_overflow;

   always_comb begin
      w_credit_next = r_credit;
      w_ovf_event   = 1'b0;
      if (credit_in && !w_send && (r_credit == DEPTH_C)) begin
         // Returned credit with a full counter: saturate and flag.
         w_ovf_event = 1'b1;
      end else if (w_send && !credit_in) begin
         w_credit_next = r_credit - 1'b1;
      end else if (!w_send && credit_in) begin
         w_credit_next = r_credit + 1'b1;
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         r_state    <= ST_IDLE;
         r_flit_idx <= '0;
         r_data     <= '0;
         r_dest     <= '0;
         r_tlast    <= 1'b0;
         r_credit   <= DEPTH_C;
         r_overflow <= 1'b0;
      end else begin
         r_credit <= w_credit_next;
         if (w_ovf_event) begin
            r_overflow <= 1'b1;
         end
         if (w_accept) begin
            r_state    <= ST_SEND;
            r_flit_idx <= '0;
            r_data     <= axis_tdata;
            r_dest     <= {axis_tid, axis_tdest};
            r_tlast    <= axis_tlast;
         end else if (w_send) begin
            if (w_last_idx) begin
               r_state    <= ST_IDLE;
               r_flit_idx <= '0;
            end else begin
               r_flit_idx <= r_flit_idx + 1'b1;
            end
         end
      end
   end

`ifdef AXIS_FLIT_INJECTOR_PERF_CNT_EN
   logic [31:0] r_perf_flits;
   logic [31:0] r_perf_stalls;

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         r_perf_flits  <= '0;
         r_perf_stalls <= '0;
      end else begin
         if (w_send) begin
            r_perf_flits <= r_perf_flits + 32'd1;
         end
         if ((r_state == ST_SEND) && (r_credit == '0)) begin
            r_perf_stalls <= r_perf_stalls + 32'd1;
         end
      end
   end

   assign perf_flits_sent    = r_perf_flits;
   assign perf_credit_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_axis_flit_injector.sv
// tb_axis_flit_injector
//   Self-checking bench for axis_flit_injector (SF=2, depth 8). A queue-based
//   reference model tracks the flits still owed for the held beat and the
//   credit balance; every cycle's outputs are compared against it.
module tb_axis_flit_injector;

   localparam int TDW   = 32;
   localparam int TDESTW = 4;
   localparam int TIDW  = 2;
   localparam int SF    = 2;
   localparam int DEPTH = 8;
   localparam int FW    = TDW / SF;
   localparam int DW    = TDESTW + TIDW;
   localparam int CW    = $clog2(DEPTH + 1);

   logic              clk_noc = 1'b0;
   logic              rst_noc_sync = 1'b1;
   logic              axis_tvalid = 1'b0;
   logic              axis_tready;
   logic [TDW-1:0]    axis_tdata = '0;
   logic              axis_tlast = 1'b0;
   logic [TIDW-1:0]   axis_tid = '0;
   logic [TDESTW-1:0] axis_tdest = '0;
   logic [FW-1:0]     data_out;
   logic [DW-1:0]     dest_out;
   logic              is_tail_out;
   logic              send_out;
   logic              credit_in = 1'b0;
   logic [CW-1:0]     credit_count;
   logic              credit_overflow;
`ifdef AXIS_FLIT_INJECTOR_PERF_CNT_EN
   logic [31:0]       perf_flits_sent;
   logic [31:0]       perf_credit_stalls;
`endif

   axis_flit_injector #(
      .TDATA_WIDTH(TDW), .TDEST_WIDTH(TDESTW), .TID_WIDTH(TIDW),
      .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEPTH)
   ) u_dut (
      .clk_noc        (clk_noc),
      .rst_noc_sync   (rst_noc_sync),
      .axis_tvalid    (axis_tvalid),
      .axis_tready    (axis_tready),
      .axis_tdata     (axis_tdata),
      .axis_tlast     (axis_tlast),
      .axis_tid       (axis_tid),
      .axis_tdest     (axis_tdest),
      .data_out       (data_out),
      .dest_out       (dest_out),
      .is_tail_out    (is_tail_out),
      .send_out       (send_out),
      .credit_in      (credit_in),
      .credit_count   (credit_count),
`ifdef AXIS_FLIT_INJECTOR_PERF_CNT_EN
      .perf_flits_sent    (perf_flits_sent),
      .perf_credit_stalls (perf_credit_stalls),
`endif
      .credit_overflow(credit_overflow)
   );

   always #5 clk_noc = ~clk_noc;

   typedef struct {
      logic [FW-1:0] data;
      logic [DW-1:0] dest;
      logic          tail;
   } flit_t;

   int    n_tests = 0;
   int    n_fail  = 0;
   flit_t m_q[$];      // flits still owed for the held beat
   int    m_credit;
   bit    m_ovf;
   bit    m_acc;       // beat accepted in the last step
   int    sent_total;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: called at a negedge, drives inputs, checks outputs
   // against the model, advances the model, returns at the next negedge.
   task automatic step(input bit v, input logic [31:0] d, input bit l,
                       input logic [TIDW-1:0] id, input logic [TDESTW-1:0] de,
                       input bit cin);
      bit    e_send;
      bit    e_ready;
      flit_t f;
      axis_tvalid = v;
      axis_tdata  = d;
      axis_tlast  = l;
      axis_tid    = id;
      axis_tdest  = de;
      credit_in   = cin;
      e_send  = (m_q.size() > 0) && (m_credit > 0);
      e_ready = (m_q.size() == 0) || (e_send && m_q.size() == 1);
      #1;
      check_eq("send", 64'(send_out), 64'(e_send));
      check_eq("ready", 64'(axis_tready), 64'(e_ready));
      check_eq("credit", 64'(credit_count), 64'(m_credit));
      check_eq("overflow", 64'(credit_overflow), 64'(m_ovf));
      if (e_send) begin
         check_eq("data", 64'(data_out), 64'(m_q[0].data));
         check_eq("dest", 64'(dest_out), 64'(m_q[0].dest));
         check_eq("tail", 64'(is_tail_out), 64'(m_q[0].tail));
         void'(m_q.pop_front());
         sent_total++;
      end
      if (cin && !e_send && m_credit == DEPTH) m_ovf = 1'b1;
      else m_credit = m_credit - int'(e_send) + int'(cin);
      m_acc = v && e_ready;
      if (m_acc) begin
         for (int i = 0; i < SF; i++) begin
            f.data = d[i*FW +: FW];
            f.dest = {id, de};
            f.tail = l && (i == SF - 1);
            m_q.push_back(f);
         end
      end
      @(posedge clk_noc);
      @(negedge clk_noc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      rst_noc_sync = 1'b1;
      axis_tvalid  = 1'b0;
      credit_in    = 1'b0;
      #1;
      check_eq("rst_send", 64'(send_out), 64'd0);
      check_eq("rst_ready", 64'(axis_tready), 64'd0);
      @(posedge clk_noc);
      @(negedge clk_noc);
      rst_noc_sync = 1'b0;
      m_q.delete();
      m_credit = DEPTH;
      m_ovf    = 1'b0;
      #1;
      check_eq("rst_credit", 64'(credit_count), 64'(DEPTH));
      check_eq("rst_data", 64'(data_out), 64'd0);
      check_eq("rst_dest", 64'(dest_out), 64'd0);
      check_eq("rst_ovf", 64'(credit_overflow), 64'd0);
   endtask

   initial begin
      int sent0;
      int b;
      int last_acc;
      sent_total = 0;
      @(negedge clk_noc);
      do_reset();
      check_eq("idle_ready", 64'(axis_tready), 64'd1);
      idle(2);

      // Single beat
      step(1'b1, 32'hDEADBEEF, 1'b1, 2'd1, 4'd5, 1'b0);
      check_eq("b0_send", 64'(send_out), 64'd1);
      check_eq("b0_data", 64'(data_out), 64'hBEEF);
      check_eq("b0_tail", 64'(is_tail_out), 64'd0);
      check_eq("b0_dest", 64'(dest_out), 64'h15);
      idle(1);
      check_eq("b1_data", 64'(data_out), 64'hDEAD);
      check_eq("b1_tail", 64'(is_tail_out), 64'd1);
      check_eq("b1_dest", 64'(dest_out), 64'h15);
      idle(1);
      check_eq("b_credit", 64'(credit_count), 64'd6);

      // Credit exhaustion with a 5-beat packet
      do_reset();
      sent0 = sent_total;
      b = 0;
      for (int i = 0; i < 14; i++) begin
         step(b < 5, $urandom, b == 4, 2'($urandom), 4'($urandom), 1'b0);
         if (m_acc) b++;
      end
      check_eq("exh_flits", 64'(sent_total - sent0), 64'd8);
      check_eq("exh_send", 64'(send_out), 64'd0);
      check_eq("exh_ready", 64'(axis_tready), 64'd0);
      check_eq("exh_credit", 64'(credit_count), 64'd0);
      step(1'b0, 32'h0, 1'b0, '0, '0, 1'b1);
      check_eq("rel_send", 64'(send_out), 64'd1);
      idle(1);
      check_eq("rel_once", 64'(send_out), 64'd0);
      idle(2);

      // Simultaneous send and credit; gap-free streaming
      do_reset();
      last_acc = -1;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, $urandom, 1'($urandom), 2'($urandom), 4'($urandom), m_credit <= 3);
         if (m_acc) begin
            if (last_acc >= 0) check_eq("acc_gap", 64'(i - last_acc), 64'd2);
            last_acc = i;
         end
      end
      check_eq("sim_credit", 64'(credit_count), 64'd3);

      // Overflow
      do_reset();
      step(1'b0, 32'h0, 1'b0, '0, '0, 1'b1);
      check_eq("ovf_credit", 64'(credit_count), 64'd8);
      check_eq("ovf_flag", 64'(credit_overflow), 64'd1);
      idle(3);
      check_eq("ovf_sticky", 64'(credit_overflow), 64'd1);

      // Reset mid-beat: second flit must never appear
      do_reset();
      step(1'b1, 32'hCAFEF00D, 1'b1, 2'd2, 4'd3, 1'b0);
      check_eq("mid_first", 64'(data_out), 64'hF00D);
      sent0 = sent_total;
      do_reset();
      check_eq("mid_send", 64'(send_out), 64'd0);
      idle(4);
      check_eq("mid_nosend", 64'(sent_total - sent0), 64'd0);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 60, $urandom, 1'($urandom), 2'($urandom),
              4'($urandom), $urandom_range(0, 99) < 40);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
